i2c_xfer_seq: RTL and testbench

Register-transfer sequencer that sits between a simple client request port and the WISHBONE slave port of the I2C master core. After reset it programs the prescaler and enables the core, then turns each client request (one-byte register write or register read on a 7-bit I2C device) into the required TXR/CR/SR/RXR access sequence. It polls TIP to pace the core and reports NACK, arbitration loss or timeout back to the client.

---
 rtl/i2c_xfer_seq_if.sv | 20 ++
 rtl/i2c_xfer_seq.sv | 210 +++++++++++++++++++++
 tb/tb_i2c_xfer_seq.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_xfer_seq_if.sv
// WISHBONE master/slave bundle between i2c_xfer_seq and the I2C master core.
interface i2c_xfer_seq_if;
  logic [2:0] wbm_adr_o;
  logic [7:0] wbm_dat_o;
  logic [7:0] wbm_dat_i;
  logic       wbm_we_o;
  logic       wbm_stb_o;
  logic       wbm_cyc_o;
  logic       wbm_ack_i;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_stb_o, wbm_cyc_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_stb_o, wbm_cyc_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/i2c_xfer_seq.sv
// Sequencer turning one-byte I2C register reads/writes into I2C master core accesses.
// Define I2C_SEQ_TIMEOUT_EN to bound each TIP poll to POLL_MAX status reads.
module i2c_xfer_seq #(
  parameter logic [15:0] PRESCALE = 16'd99
`ifdef I2C_SEQ_TIMEOUT_EN
  , parameter int unsigned POLL_MAX = 1024
`endif
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       req_i,
  input  logic       rnw_i,
  input  logic [6:0] dev_i,
  input  logic [7:0] reg_i,
  input  logic [7:0] wdata_i,
  output logic       ready_o,
  output logic       done_o,
  output logic [1:0] err_o,
  output logic [7:0] rdata_o,
  i2c_xfer_seq_if.master wbm
);

  typedef enum logic [3:0] {
    S_INIT_LO, S_INIT_HI, S_INIT_CTR, S_IDLE, S_TXR, S_CR,
    S_WAIT, S_RXR, S_STOP, S_STOP_WAIT, S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic       stb_q, stb_d, we_q, we_d;
  logic [2:0] adr_q, adr_d;
  logic [7:0] dat_q, dat_d;
  logic [1:0] phase_q, phase_d, err_q, err_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rnw_q, rnw_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] rg_q, rg_d, wdata_q, wdata_d;
`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int unsigned CW = $clog2(POLL_MAX + 1);
  logic [CW-1:0] poll_q, poll_d;
`endif

  logic       acc_en, acc_we, xfer_done;
  logic [2:0] acc_adr;
  logic [7:0] acc_dat, txr_val, cr_val;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q <= S_INIT_LO;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      phase_q <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      rnw_q   <= 1'b0;
      dev_q   <= '0;
      rg_q    <= '0;
      wdata_q <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
      poll_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      phase_q <= phase_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rnw_q   <= rnw_d;
      dev_q   <= dev_d;
      rg_q    <= rg_d;
      wdata_q <= wdata_d;
`ifdef I2C_SEQ_TIMEOUT_EN
      poll_q  <= poll_d;
`endif
    end
  end

  // Per-state bus access descriptor; phase 3 exists only for reads.
  always_comb begin
    txr_val = '0;
    cr_val  = '0;
    case (phase_q)
      2'd0:    begin txr_val = {dev_q, 1'b0}; cr_val = 8'h90; end
      2'd1:    begin txr_val = rg_q;          cr_val = 8'h10; end
      2'd2:    begin
        txr_val = rnw_q ? {dev_q, 1'b1} : wdata_q;
        cr_val  = rnw_q ? 8'h90 : 8'h50;
      end
      default: cr_val = 8'h68;
    endcase
    acc_en  = 1'b1;
    acc_adr = '0;
    acc_dat = '0;
    acc_we  = 1'b0;
    case (state_q)
      S_INIT_LO:           begin acc_adr = 3'd0; acc_dat = PRESCALE[7:0];  acc_we = 1'b1; end
      S_INIT_HI:           begin acc_adr = 3'd1; acc_dat = PRESCALE[15:8]; acc_we = 1'b1; end
      S_INIT_CTR:          begin acc_adr = 3'd2; acc_dat = 8'h80;          acc_we = 1'b1; end
      S_TXR:               begin acc_adr = 3'd3; acc_dat = txr_val;        acc_we = 1'b1; end
      S_CR:                begin acc_adr = 3'd4; acc_dat = cr_val;         acc_we = 1'b1; end
      S_STOP:              begin acc_adr = 3'd4; acc_dat = 8'h40;          acc_we = 1'b1; end
      S_WAIT, S_STOP_WAIT: acc_adr = 3'd4;
      S_RXR:               acc_adr = 3'd3;
      default:             acc_en = 1'b0;
    endcase
    xfer_done = stb_q & wbm.wbm_ack_i;
  end

  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    phase_d = phase_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    rnw_d   = rnw_q;
    dev_d   = dev_q;
    rg_d    = rg_q;
    wdata_d = wdata_q;
`ifdef I2C_SEQ_TIMEOUT_EN
    poll_d  = poll_q;
`endif
    // An access state launches in its first cycle with stb low, which also
    // guarantees one idle bus cycle between consecutive accesses.
    if (acc_en) begin
      if (!stb_q) begin
        stb_d = 1'b1;
        adr_d = acc_adr;
        dat_d = acc_dat;
        we_d  = acc_we;
      end else if (wbm.wbm_ack_i) begin
        stb_d = 1'b0;
      end
    end
    case (state_q)
      S_INIT_LO:  if (xfer_done) state_d = S_INIT_HI;
      S_INIT_HI:  if (xfer_done) state_d = S_INIT_CTR;
      S_INIT_CTR: if (xfer_done) state_d = S_IDLE;
      S_IDLE: if (req_i) begin
        rnw_d   = rnw_i;
        dev_d   = dev_i;
        rg_d    = reg_i;
        wdata_d = wdata_i;
        phase_d = '0;
        err_d   = '0;
        state_d = S_TXR;
      end
      S_TXR: if (xfer_done) state_d = S_CR;
      S_CR: if (xfer_done) begin
        state_d = S_WAIT;
`ifdef I2C_SEQ_TIMEOUT_EN
        poll_d  = '0;
`endif
      end
      S_WAIT: if (xfer_done) begin
        if (!wbm.wbm_dat_i[1]) begin
          if (wbm.wbm_dat_i[5]) begin
            err_d   = 2'd2;
            state_d = S_DONE;
          end else if (wbm.wbm_dat_i[7] && phase_q != 2'd3) begin
            err_d   = 2'd1;
            state_d = S_STOP;
          end else if (phase_q == 2'd3) begin
            state_d = S_RXR;
          end else if (phase_q == 2'd2 && !rnw_q) begin
            state_d = S_DONE;
          end else begin
            phase_d = phase_q + 2'd1;
            state_d = (phase_q == 2'd2) ? S_CR : S_TXR;
          end
        end
`ifdef I2C_SEQ_TIMEOUT_EN
        else if (poll_q == CW'(POLL_MAX - 1)) begin
          err_d   = 2'd3;
          state_d = S_STOP;
        end else begin
          poll_d = poll_q + CW'(1);
        end
`endif
      end
      S_RXR: if (xfer_done) begin
        rdata_d = wbm.wbm_dat_i;
        state_d = S_DONE;
      end
      S_STOP:      if (xfer_done) state_d = S_STOP_WAIT;
      S_STOP_WAIT: if (xfer_done && !wbm.wbm_dat_i[1]) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_INIT_LO;
    endcase
  end

  always_comb begin
    ready_o       = (state_q == S_IDLE);
    done_o        = (state_q == S_DONE);
    err_o         = err_q;
    rdata_o       = rdata_q;
    wbm.wbm_adr_o = adr_q;
    wbm.wbm_dat_o = dat_q;
    wbm.wbm_we_o  = we_q;
    wbm.wbm_stb_o = stb_q;
    wbm.wbm_cyc_o = stb_q;
  end

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Bench for i2c_xfer_seq: behavioural I2C core slave, table vectors, random vectors, corner sequences.
module tb_i2c_xfer_seq;
`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int unsigned PM = 4;
`else
  localparam int unsigned PM = 1024;
`endif

  logic       clk = 1'b0;
  logic       wb_rst_i = 1'b0;
  logic       req_i = 1'b0, rnw_i = 1'b0;
  logic [6:0] dev_i = '0;
  logic [7:0] reg_i = '0, wdata_i = '0;
  logic       ready_o, done_o;
  logic [1:0] err_o;
  logic [7:0] rdata_o;

  i2c_xfer_seq_if bus ();

  i2c_xfer_seq #(
    .PRESCALE(16'd99)
`ifdef I2C_SEQ_TIMEOUT_EN
    , .POLL_MAX(PM)
`endif
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .req_i(req_i), .rnw_i(rnw_i),
    .dev_i(dev_i), .reg_i(reg_i), .wdata_i(wdata_i), .ready_o(ready_o),
    .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .wbm(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rnw;
    logic [6:0]  dev;
    logic [7:0]  rg;
    logic [7:0]  wdata;
    int unsigned tip;      // SR reads showing TIP=1 after each CR write
    int unsigned nack_at;  // 1-based CR write index whose wait ends with RxACK=1 (0 = none)
    int unsigned al_at;    // same for AL=1
    logic        stuck;    // TIP never clears for non-STOP commands
    logic [7:0]  rxr;
    int unsigned delay;    // ack wait states
    logic [1:0]  exp_err;
    logic [7:0]  exp_rd;
  } vec_t;

  int n_tests = 0, n_fail = 0;

  // ---- behavioural core slave ----
  int unsigned sc_tip = 0, sc_nack = 0, sc_al = 0, ack_delay = 0, cr_base = 0;
  logic        sc_stuck = 1'b0;
  logic [7:0]  sc_rxr = '0;
  int unsigned cr_cnt = 0, sr_reads = 0, tip_left = 0, wcnt = 0, cyc_n = 0;
  logic [7:0]  last_cr = '0;
  logic [10:0] wlog[$];
  int unsigned wstamp[$];
  logic [7:0]  sr_v;

  always_comb begin
    sr_v = '0;
    sr_v[1] = (tip_left > 0) || (sc_stuck && last_cr != 8'h40);
    sr_v[5] = (sc_al != 0) && ((cr_cnt - cr_base) == sc_al);
    sr_v[7] = (sc_nack != 0) && ((cr_cnt - cr_base) == sc_nack);
  end
  assign bus.wbm_dat_i = (bus.wbm_adr_o == 3'd3) ? sc_rxr : (bus.wbm_adr_o == 3'd4) ? sr_v : 8'h00;
  assign bus.wbm_ack_i = bus.wbm_stb_o && (wcnt >= ack_delay);

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (bus.wbm_stb_o && !bus.wbm_ack_i) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (bus.wbm_stb_o && bus.wbm_ack_i) begin
      if (bus.wbm_we_o) begin
        wlog.push_back({bus.wbm_adr_o, bus.wbm_dat_o});
        wstamp.push_back(cyc_n);
        if (bus.wbm_adr_o == 3'd4) begin
          cr_cnt   <= cr_cnt + 1;
          last_cr  <= bus.wbm_dat_o;
          tip_left <= sc_tip;
        end
      end else if (bus.wbm_adr_o == 3'd4) begin
        sr_reads <= sr_reads + 1;
        if (tip_left > 0) tip_left <= tip_left - 1;
      end
    end
  end

  // Bus protocol watch: stb==cyc, stable fields while stretched, drop after ack.
  int unsigned viol = 0;
  logic p_stb = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [2:0] p_adr = '0;
  logic [7:0] p_dat = '0;
  always @(negedge clk) begin
    if (wb_rst_i) begin
      if (bus.wbm_stb_o !== bus.wbm_cyc_o) viol++;
      if (p_stb && !p_ack && bus.wbm_stb_o &&
          (bus.wbm_adr_o !== p_adr || bus.wbm_dat_o !== p_dat || bus.wbm_we_o !== p_we)) viol++;
      if (p_stb && p_ack && bus.wbm_stb_o) viol++;
    end
    p_stb = bus.wbm_stb_o; p_ack = bus.wbm_ack_i;
    p_adr = bus.wbm_adr_o; p_dat = bus.wbm_dat_o; p_we = bus.wbm_we_o;
  end

  // ---- reference model ----
  logic [10:0] exp_q[$];
  logic [7:0]  last_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model(input vec_t v, output logic [1:0] err, output int unsigned nsr);
    logic [7:0] txr[4];
    logic [7:0] cr[4];
    int unsigned n;
    exp_q.delete();
    err = 2'd0;
    nsr = 0;
    n = v.rnw ? 4 : 3;
    txr[0] = {v.dev, 1'b0};
    txr[1] = v.rg;
    txr[2] = v.rnw ? {v.dev, 1'b1} : v.wdata;
    txr[3] = 8'h00;
    cr[0] = 8'h90;
    cr[1] = 8'h10;
    cr[2] = v.rnw ? 8'h90 : 8'h50;
    cr[3] = 8'h68;
    for (int unsigned p = 0; p < n; p++) begin
      if (p < 3) exp_q.push_back({3'd3, txr[p]});
      exp_q.push_back({3'd4, cr[p]});
      if (v.stuck) begin exp_q.push_back({3'd4, 8'h40}); err = 2'd3; break; end
      if (v.al_at == p + 1) begin err = 2'd2; break; end
      if (v.nack_at == p + 1 && cr[p][4]) begin exp_q.push_back({3'd4, 8'h40}); err = 2'd1; break; end
    end
    foreach (exp_q[i])
      if (exp_q[i][10:8] == 3'd4)
        nsr += (v.stuck && exp_q[i][7:0] != 8'h40) ? PM : v.tip + 1;
  endtask

  task automatic wait_ready(input string tag);
    for (int c = 0; c < 2000 && !ready_o; c++) @(negedge clk);
    if (!ready_o) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_vec(input vec_t v, input logic [1:0] x_err, input logic [7:0] x_rd,
                        input bit spam, input string tag);
    logic [1:0]  m_err;
    int unsigned m_sr, base, srb, n;
    bit          seen;
    model(v, m_err, m_sr);
    wait_ready(tag);
    sc_tip = v.tip; sc_nack = v.nack_at; sc_al = v.al_at; sc_stuck = v.stuck;
    sc_rxr = v.rxr; ack_delay = v.delay;
    cr_base = cr_cnt; base = wlog.size(); srb = sr_reads;
    rnw_i = v.rnw; dev_i = v.dev; reg_i = v.rg; wdata_i = v.wdata; req_i = 1'b1;
    @(negedge clk);
    req_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      if (spam && c == 3) begin req_i = 1'b1; dev_i = 7'h11; end
      if (spam && c == 5) req_i = 1'b0;
      @(negedge clk);
      if (done_o) seen = 1;
    end
    if (!seen) begin
      check({tag, "_done_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_err"}, err_o, x_err);
    check({tag, "_rdata"}, rdata_o, x_rd);
    n = wlog.size() - base;
    check({tag, "_nwrites"}, n, exp_q.size());
    for (int unsigned i = 0; i < n && i < exp_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), wlog[base + i], exp_q[i]);
    check({tag, "_sr_reads"}, sr_reads - srb, m_sr);
    if (v.rnw && m_err == 2'd0) last_rd = v.rxr;
    @(negedge clk);
    check({tag, "_done_pulse"}, done_o, 1'b0);
    check({tag, "_ready_after"}, ready_o, 1'b1);
  endtask

  vec_t tbl[8];
  vec_t r;

  initial begin
    int unsigned b0;
    logic [1:0]  me;
    int unsigned ms;
    tbl[0] = '{1'b0, 7'h50, 8'h12, 8'hA5, 2, 0, 0, 1'b0, 8'h00, 0, 2'd0, 8'h00};
    tbl[1] = '{1'b1, 7'h50, 8'h34, 8'h00, 0, 0, 0, 1'b0, 8'h5C, 0, 2'd0, 8'h5C};
    tbl[2] = '{1'b0, 7'h50, 8'h12, 8'hA5, 1, 1, 0, 1'b0, 8'h00, 0, 2'd1, 8'h5C};
    tbl[3] = '{1'b0, 7'h2A, 8'h07, 8'h3C, 0, 0, 2, 1'b0, 8'h00, 0, 2'd2, 8'h5C};
    tbl[4] = '{1'b1, 7'h7F, 8'hFF, 8'h00, 0, 3, 0, 1'b0, 8'h99, 1, 2'd1, 8'h5C};
    tbl[5] = '{1'b0, 7'h01, 8'h80, 8'h01, 1, 0, 0, 1'b0, 8'h00, 5, 2'd0, 8'h5C};
    tbl[6] = '{1'b1, 7'h33, 8'h44, 8'h00, 1, 4, 0, 1'b0, 8'h3C, 0, 2'd0, 8'h3C};
    tbl[7] = '{1'b1, 7'h33, 8'h45, 8'h00, 0, 0, 4, 1'b0, 8'hC3, 0, 2'd2, 8'h3C};

    // Reset values and INIT sequence
    repeat (3) @(negedge clk);
    check("rst_ready", ready_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_err", err_o, 2'd0);
    check("rst_rdata", rdata_o, 8'h00);
    check("rst_stb_cyc_we", {bus.wbm_stb_o, bus.wbm_cyc_o, bus.wbm_we_o}, 3'b000);
    check("rst_adr_dat", {bus.wbm_adr_o, bus.wbm_dat_o}, 11'h000);
    wb_rst_i = 1'b1;
    wait_ready("init");
    check("init_nwrites", wlog.size(), 3);
    if (wlog.size() >= 3) begin
      check("init_prerlo", wlog[0], {3'd0, 8'h63});
      check("init_prerhi", wlog[1], {3'd1, 8'h00});
      check("init_ctr", wlog[2], {3'd2, 8'h80});
      check("init_gap1", wstamp[1] - wstamp[0], 2);
      check("init_gap2", wstamp[2] - wstamp[1], 2);
    end

    foreach (tbl[i]) do_vec(tbl[i], tbl[i].exp_err, tbl[i].exp_rd, 1'b0, $sformatf("tbl%0d", i));

    // Request while busy is dropped
    r = '{1'b0, 7'h5A, 8'h21, 8'h77, 0, 0, 0, 1'b0, 8'h00, 0, 2'd0, 8'h00};
    do_vec(r, 2'd0, last_rd, 1'b1, "busy_req");

`ifdef I2C_SEQ_TIMEOUT_EN
    r = '{1'b0, 7'h50, 8'h12, 8'hA5, 0, 0, 0, 1'b1, 8'h00, 0, 2'd3, 8'h00};
    do_vec(r, 2'd3, last_rd, 1'b0, "timeout");
`endif

    for (int k = 0; k < 24; k++) begin
      r.rnw = 1'($urandom_range(0, 1));
      r.dev = 7'($urandom);
      r.rg = 8'($urandom);
      r.wdata = 8'($urandom);
      r.tip = $urandom_range(0, 3);
      r.nack_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, r.rnw ? 4 : 3) : 0;
      r.al_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, r.rnw ? 4 : 3) : 0;
`ifdef I2C_SEQ_TIMEOUT_EN
      r.stuck = ($urandom_range(0, 7) == 0);
`else
      r.stuck = 1'b0;
`endif
      r.rxr = 8'($urandom);
      r.delay = $urandom_range(0, 2);
      model(r, me, ms);
      do_vec(r, me, (r.rnw && me == 2'd0) ? r.rxr : last_rd, 1'b0, $sformatf("rnd%0d", k));
    end

    check("bus_protocol_violations", viol, 0);

    // Reset mid-access: stb drops at once, no STOP, INIT reruns
    wait_ready("mid");
    sc_tip = 0; sc_nack = 0; sc_al = 0; sc_stuck = 1'b0; ack_delay = 5;
    b0 = wlog.size();
    rnw_i = 1'b0; dev_i = 7'h50; reg_i = 8'h12; wdata_i = 8'hA5; req_i = 1'b1;
    @(negedge clk);
    req_i = 1'b0;
    for (int c = 0; c < 50 && !bus.wbm_stb_o; c++) @(negedge clk);
    check("mid_stb_seen", bus.wbm_stb_o, 1'b1);
    wb_rst_i = 1'b0;
    @(negedge clk);
    check("mid_stb_drop", {bus.wbm_stb_o, bus.wbm_cyc_o}, 2'b00);
    check("mid_ready_low", ready_o, 1'b0);
    @(negedge clk);
    ack_delay = 0;
    wb_rst_i = 1'b1;
    wait_ready("mid_init");
    check("mid_nwrites", wlog.size() - b0, 3);
    if (wlog.size() - b0 >= 3) begin
      check("mid_prerlo", wlog[b0], {3'd0, 8'h63});
      check("mid_prerhi", wlog[b0 + 1], {3'd1, 8'h00});
      check("mid_ctr", wlog[b0 + 2], {3'd2, 8'h80});
    end
    check("mid_rdata", rdata_o, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
